// File: rtl/sha256_block_engine_if.sv
// Word-stream input and digest output bundle for the SHA-256 block engine.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low. The consumer may raise or drop ready at any time. The producer's valid
// does not depend combinationally on ready.
interface sha256_block_engine_if;
  logic [31:0]  data_in;
  logic         data_in_first;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [255:0] hash_out;
  logic         hash_out_valid;
  logic         hash_out_ready;

  // Host side: supplies message words and accepts digests.
  modport master (
    output data_in, data_in_first, data_in_valid, hash_out_ready,
    input  data_in_ready, hash_out, hash_out_valid
  );

  // Engine side.
  modport slave (
    input  data_in, data_in_first, data_in_valid, hash_out_ready,
    output data_in_ready, hash_out, hash_out_valid
  );
endinterface

// File: rtl/sha256_block_engine.sv
// SHA-256 block engine: loads 16 message words, runs the compression rounds
// one per clock with a 16-word circular message schedule, adds the result into
// the chaining state and presents the 256-bit intermediate digest.
module sha256_block_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  sha256_block_engine_if.slave bus,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_ROUND  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------------------------------------------------------- functions
  function automatic word_t rotr(input word_t x, input int unsigned n);
    rotr = (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  function automatic word_t ssig0(input word_t x);
    ssig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    ssig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t bsig0(input word_t x);
    bsig0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    bsig1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    ch = (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    maj = (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // ---------------------------------------------------------------- state
  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;        // words accepted in current block
  logic [6:0]   rnd_q, rnd_d;        // round index t
  word_t        w_q  [16];           // circular message schedule
  word_t        w_d  [16];
  word_t        wv_q [8];            // working variables a..h
  word_t        wv_d [8];
  word_t        hs_q [8];            // chaining state H0..H7
  word_t        hs_d [8];
  logic [255:0] hash_q, hash_d;
  logic         hvalid_q, hvalid_d;
  logic         ready_q, ready_d;

  logic         in_fire;
  logic [3:0]   t_idx;
  word_t        w_sched;
  word_t        w_t;
  word_t        t1;
  word_t        t2;

  assign in_fire = bus.data_in_valid && ready_q;
  assign t_idx   = rnd_q[3:0];

  // Schedule word for t >= 16; (t-16) mod 16 and t mod 16 share a slot, so
  // the oldest word is read from the slot about to be overwritten.
  assign w_sched = ssig1(w_q[t_idx - 4'd2]) + w_q[t_idx - 4'd7]
                 + ssig0(w_q[t_idx - 4'd15]) + w_q[t_idx];
  assign w_t     = (rnd_q < 7'd16) ? w_q[t_idx] : w_sched;

  assign t1 = wv_q[7] + bsig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6])
            + K[rnd_q[5:0]] + w_t;
  assign t2 = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

  // Next-state logic for the LOAD -> ROUND -> UPDATE -> OUTPUT sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnd_d    = rnd_q;
    w_d      = w_q;
    wv_d     = wv_q;
    hs_d     = hs_q;
    hash_d   = hash_q;
    hvalid_d = hvalid_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          w_d[cnt_q] = bus.data_in;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            // First block of a message restarts from the IV; otherwise chain.
            if (bus.data_in_first) begin
              wv_d = IV;
              hs_d = IV;
            end else begin
              wv_d = hs_q;
            end
          end
          if (cnt_q == 4'd15) begin
            state_d = ST_ROUND;
            rnd_d   = '0;
          end
        end
      end
      ST_ROUND: begin
        w_d[t_idx] = w_t;
        wv_d[7]    = wv_q[6];
        wv_d[6]    = wv_q[5];
        wv_d[5]    = wv_q[4];
        wv_d[4]    = wv_q[3] + t1;
        wv_d[3]    = wv_q[2];
        wv_d[2]    = wv_q[1];
        wv_d[1]    = wv_q[0];
        wv_d[0]    = t1 + t2;
        rnd_d      = rnd_q + 7'd1;
        if (rnd_q == LAST_ROUND) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < 8; i++) begin
          hs_d[i] = hs_q[i] + wv_q[i];
        end
        for (int i = 0; i < 8; i++) begin
          hash_d[(7 - i) * 32 +: 32] = hs_d[i];
        end
        hvalid_d = 1'b1;
        state_d  = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        // Digest register keeps its value after the handoff.
        if (bus.hash_out_ready) begin
          hvalid_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    // Registered so ready stays low throughout reset and rises on the first edge.
    ready_d = (state_d == ST_LOAD);
  end

  // State registers; reset discards any partial block and restores the IV.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      rnd_q    <= '0;
      w_q      <= '{default: '0};
      wv_q     <= '{default: '0};
      hs_q     <= IV;
      hash_q   <= '0;
      hvalid_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnd_q    <= rnd_d;
      w_q      <= w_d;
      wv_q     <= wv_d;
      hs_q     <= hs_d;
      hash_q   <= hash_d;
      hvalid_q <= hvalid_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.data_in_ready  = ready_q;
  assign bus.hash_out       = hash_q;
  assign bus.hash_out_valid = hvalid_q;
  assign busy               = !((state_q == ST_LOAD) && (cnt_q == 4'd0));
  assign dbg_state_o        = state_q;

endmodule
